// File: rtl/inst_rom_resp_if.sv
// Instruction-fetch bus between the PC/loader side (master) and the
// instruction ROM responder (slave).
// Optional macro: INST_ROM_ALIGN_CHK_EN adds the fetch_err_o flag.
interface inst_rom_resp_if #(
   parameter int ADDR_W = 10
);
   logic              ce_i;
   logic [31:0]       pc_i;
   logic [31:0]       inst_o;
   logic              inst_valid_o;
   logic              stallreq_o;
   logic              ld_we_i;
   logic [ADDR_W-1:0] ld_addr_i;
   logic [31:0]       ld_data_i;
`ifdef INST_ROM_ALIGN_CHK_EN
   logic              fetch_err_o;

   modport master (
      output ce_i, pc_i, ld_we_i, ld_addr_i, ld_data_i,
      input  inst_o, inst_valid_o, stallreq_o, fetch_err_o
   );
   modport slave (
      input  ce_i, pc_i, ld_we_i, ld_addr_i, ld_data_i,
      output inst_o, inst_valid_o, stallreq_o, fetch_err_o
   );
`else
   modport master (
      output ce_i, pc_i, ld_we_i, ld_addr_i, ld_data_i,
      input  inst_o, inst_valid_o, stallreq_o
   );
   modport slave (
      input  ce_i, pc_i, ld_we_i, ld_addr_i, ld_data_i,
      output inst_o, inst_valid_o, stallreq_o
   );
`endif
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: slow word-addressed memory with WAIT_STATES
// extra cycles per fetch, a stall request while the current pc is not yet
// served, and a loader write port that is never blocked.
// Optional macro: INST_ROM_ALIGN_CHK_EN flags misaligned / out-of-range
// fetch addresses and answers them at once with a NOP.
module inst_rom_resp #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic           clk,
   input  logic           rst,
   inst_rom_resp_if.slave bus
);
   localparam int         DEPTH   = 2**ADDR_W;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READ} state_t;

   // With no wait states a new fetch goes straight to the array read
   localparam state_t FETCH_ST = (WAIT_STATES == 0) ? ST_READ : ST_WAIT;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg;
   logic [31:0]       req_pc_reg;
   logic [31:0]       served_pc_reg;
   logic              served_valid_reg;
   logic [31:0]       data_reg;
   logic [31:0]       mem [DEPTH];

   logic [ADDR_W-1:0] req_idx;
   logic [ADDR_W-1:0] served_idx;
   logic              hit;
   logic              addr_err;
   logic              miss;
   logic              redirect;
   logic              start_fetch;
   logic              cnt_dec;
   logic              serve;
   logic              inst_valid;
   logic              stallreq;
   logic [31:0]       inst;

   assign req_idx    = req_pc_reg[ADDR_W+1:2];
   assign served_idx = served_pc_reg[ADDR_W+1:2];
   assign hit        = served_valid_reg && (served_pc_reg == bus.pc_i);
   assign redirect   = (bus.pc_i != req_pc_reg);

`ifdef INST_ROM_ALIGN_CHK_EN
   // Misaligned or beyond-array addresses never reach the FSM
   assign addr_err        = (bus.pc_i[1:0] != 2'b00) || (bus.pc_i[31:ADDR_W+2] != '0);
   assign bus.fetch_err_o = bus.ce_i && addr_err;
`else
   assign addr_err = 1'b0;
`endif

   assign miss = bus.ce_i && !hit && !addr_err;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a pc change mid-fetch restarts, ce_i low abandons
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (miss) state_next = FETCH_ST;
         end
         ST_WAIT: begin
            if (!bus.ce_i)           state_next = ST_IDLE;
            else if (redirect)       state_next = miss ? FETCH_ST : ST_IDLE;
            else if (cnt_reg == 4'd1) state_next = ST_READ;
         end
         ST_READ: begin
            if (bus.ce_i && redirect && miss) state_next = FETCH_ST;
            else                              state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic: datapath controls and the combinational bus responses
   always_comb begin
      start_fetch = miss && ((state_reg == ST_IDLE) || redirect);
      cnt_dec     = (state_reg == ST_WAIT) && bus.ce_i && !redirect;
      serve       = (state_reg == ST_READ) && bus.ce_i && !redirect;
      inst_valid  = bus.ce_i && (hit || addr_err);
      stallreq    = miss;
      inst        = (bus.ce_i && hit) ? data_reg : 32'h0000_0000;
   end

   assign bus.inst_o       = inst;
   assign bus.inst_valid_o = inst_valid;
   assign bus.stallreq_o   = stallreq;

   // Loader write port into the instruction array (contents survive reset)
   always_ff @(posedge clk) begin
      if (bus.ld_we_i) begin
         mem[bus.ld_addr_i] <= bus.ld_data_i;
      end
   end

   // Fetch datapath: request latch, wait counter and served-word tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg          <= 4'd0;
         req_pc_reg       <= 32'h0;
         served_pc_reg    <= 32'h0;
         served_valid_reg <= 1'b0;
         data_reg         <= 32'h0;
      end else begin
         if (start_fetch) begin
            req_pc_reg <= bus.pc_i;
            cnt_reg    <= WAIT_LD;
         end else if (cnt_dec) begin
            cnt_reg <= cnt_reg - 4'd1;
         end

         // A rewrite of the served word invalidates it so it is refetched
         if (!bus.ce_i) begin
            served_valid_reg <= 1'b0;
         end else if (bus.ld_we_i && (bus.ld_addr_i == served_idx)) begin
            served_valid_reg <= 1'b0;
         end

         // Write-first: a same-edge loader write to the read index wins
         if (serve) begin
            data_reg         <= (bus.ld_we_i && (bus.ld_addr_i == req_idx)) ?
                                bus.ld_data_i : mem[req_idx];
            served_pc_reg    <= req_pc_reg;
            served_valid_reg <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: one DUT with WAIT_STATES=2 and one with
// WAIT_STATES=0, both driven from the same fetch/loader stimulus.
module tb_inst_rom_resp;
   logic        clk;
   logic        rst;
   logic        ce;
   logic [31:0] pc;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   int n_cmp = 0;
   int n_err = 0;
   int c2;
   int c0;

   inst_rom_resp_if #(.ADDR_W(10)) bus2 ();
   inst_rom_resp_if #(.ADDR_W(10)) bus0 ();

   assign bus2.ce_i      = ce;
   assign bus2.pc_i      = pc;
   assign bus2.ld_we_i   = ld_we;
   assign bus2.ld_addr_i = ld_addr;
   assign bus2.ld_data_i = ld_data;
   assign bus0.ce_i      = ce;
   assign bus0.pc_i      = pc;
   assign bus0.ld_we_i   = ld_we;
   assign bus0.ld_addr_i = ld_addr;
   assign bus0.ld_data_i = ld_data;

   inst_rom_resp #(.ADDR_W(10), .WAIT_STATES(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   inst_rom_resp #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out2(input string tag, input logic [31:0] i, input logic v, input logic s);
      chk({tag, "_inst"},  bus2.inst_o, i);
      chk({tag, "_valid"}, {31'b0, bus2.inst_valid_o}, {31'b0, v});
      chk({tag, "_stall"}, {31'b0, bus2.stallreq_o}, {31'b0, s});
   endtask

   // Count stall cycles of each DUT until both report a hit (bounded)
   task automatic wait_fetch(output int s2, output int s0);
      int n;
      s2 = 0;
      s0 = 0;
      n  = 0;
      #1;
      while ((bus2.stallreq_o || bus0.stallreq_o) && n < 20) begin
         if (bus2.stallreq_o) s2++;
         if (bus0.stallreq_o) s0++;
         n++;
         tick();
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_we   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; pc = 32'h0;
      ld_we = 1'b0; ld_addr = '0; ld_data = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk_out2("reset", 32'h0, 1'b0, 1'b0);
      $display("txn reset: inst=%h valid=%b stall=%b", bus2.inst_o, bus2.inst_valid_o, bus2.stallreq_o);

      load(10'd0, 32'h3401_0001);
      load(10'd1, 32'h3402_0002);
      load(10'd2, 32'h3403_0003);
      $display("txn load: 3 words written");

      // First fetch of 0x0
      ce = 1'b1; pc = 32'h0;
      wait_fetch(c2, c0);
      chk("f0_stall_cycles_ws2", 32'(c2), 32'd4);
      chk("f0_stall_cycles_ws0", 32'(c0), 32'd2);
      chk_out2("f0_hit", 32'h3401_0001, 1'b1, 1'b0);
      chk("f0_inst_ws0", bus0.inst_o, 32'h3401_0001);
      $display("txn fetch pc=0: stall2=%0d stall0=%0d inst=%h", c2, c0, bus2.inst_o);

      // Holding the served pc keeps the hit
      tick();
      chk_out2("hold0", 32'h3401_0001, 1'b1, 1'b0);
      $display("txn hold pc=0: inst=%h valid=%b", bus2.inst_o, bus2.inst_valid_o);

      pc = 32'h4;
      wait_fetch(c2, c0);
      chk("f4_stall_cycles", 32'(c2), 32'd4);
      chk_out2("f4_hit", 32'h3402_0002, 1'b1, 1'b0);
      $display("txn fetch pc=4: stall=%0d inst=%h", c2, bus2.inst_o);

      pc = 32'h0;
      #1;
      chk_out2("re0_miss", 32'h0, 1'b0, 1'b1);
      wait_fetch(c2, c0);
      chk("re0_stall_cycles", 32'(c2), 32'd4);
      chk_out2("re0_hit", 32'h3401_0001, 1'b1, 1'b0);
      $display("txn refetch pc=0: stall=%0d inst=%h", c2, bus2.inst_o);

      pc = 32'h8;
      wait_fetch(c2, c0);
      chk_out2("f8_hit", 32'h3403_0003, 1'b1, 1'b0);
      $display("txn fetch pc=8: stall=%0d inst=%h", c2, bus2.inst_o);

      // Redirect from 0x4 to 0x0 after one wait cycle
      pc = 32'h4;
      tick();
      tick();
      chk_out2("redir_wait", 32'h0, 1'b0, 1'b1);
      pc = 32'h0;
      wait_fetch(c2, c0);
      chk("redir_stall_cycles", 32'(c2), 32'd4);
      chk_out2("redir_hit", 32'h3401_0001, 1'b1, 1'b0);
      pc = 32'h4;
      #1;
      chk_out2("redir_stale4", 32'h0, 1'b0, 1'b1);
      pc = 32'h0;
      #1;
      chk_out2("redir_back0", 32'h3401_0001, 1'b1, 1'b0);
      $display("txn redirect 4->0: stall=%0d inst=%h", c2, bus2.inst_o);

      // Loader overwrites the served word
      load(10'd0, 32'hFFFF_0000);
      #1;
      chk_out2("ldinv", 32'h0, 1'b0, 1'b1);
      wait_fetch(c2, c0);
      chk("ldinv_stall_cycles", 32'(c2), 32'd4);
      chk_out2("ldinv_hit", 32'hFFFF_0000, 1'b1, 1'b0);
      $display("txn loader invalidate pc=0: stall=%0d inst=%h", c2, bus2.inst_o);

      // Loader write to the index being read in READ is seen (write-first)
      pc = 32'h4;
      tick();
      tick();
      tick();
      ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hA5A5_A5A5;
      #1;
      chk_out2("wf_read", 32'h0, 1'b0, 1'b1);
      tick();
      ld_we = 1'b0;
      #1;
      chk_out2("wf_hit", 32'hA5A5_A5A5, 1'b1, 1'b0);
      $display("txn write-first pc=4: inst=%h", bus2.inst_o);

      // ce_i low: outputs drop at once, served word forgotten at the edge
      ce = 1'b0;
      #1;
      chk_out2("ce_low", 32'h0, 1'b0, 1'b0);
      tick();
      ce = 1'b1;
      #1;
      chk_out2("ce_back", 32'h0, 1'b0, 1'b1);
      $display("txn ce drop: stall=%b", bus2.stallreq_o);

      // Reset in the middle of a fetch
      pc = 32'h8;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ce  = 1'b0;
      #1;
      chk_out2("rst_mid", 32'h0, 1'b0, 1'b0);
      chk("rst_mid_ws0_stall", {31'b0, bus0.stallreq_o}, 32'h0);
      tick();
      ce = 1'b1; pc = 32'h4;
      wait_fetch(c2, c0);
      chk("post_rst_stall_ws2", 32'(c2), 32'd4);
      chk("post_rst_stall_ws0", 32'(c0), 32'd2);
      chk_out2("post_rst_hit", 32'hA5A5_A5A5, 1'b1, 1'b0);
      chk("post_rst_inst_ws0", bus0.inst_o, 32'hA5A5_A5A5);
      $display("txn post-reset fetch pc=4: stall2=%0d stall0=%0d inst=%h", c2, c0, bus2.inst_o);

`ifdef INST_ROM_ALIGN_CHK_EN
      pc = 32'h2;
      #1;
      chk("err_low_flag", {31'b0, bus2.fetch_err_o}, 32'h1);
      chk_out2("err_low", 32'h0, 1'b1, 1'b0);
      pc = 32'h0001_0000;
      #1;
      chk("err_high_flag", {31'b0, bus2.fetch_err_o}, 32'h1);
      chk_out2("err_high", 32'h0, 1'b1, 1'b0);
      pc = 32'h4;
      #1;
      chk("err_clear_flag", {31'b0, bus2.fetch_err_o}, 32'h0);
      $display("txn align check: err=%b", bus2.fetch_err_o);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
